// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bus for one data-memory port: request payload plus grant and response.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, wr, size, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port data-memory arbiter: port 0 fixed priority, alignment/size checking, registered responses.
// DMEM_ARB_STARVE_GUARD_EN builds the port-1 starvation counter and forced grant.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    dmem_port_arbiter_if.slave  m0,
    dmem_port_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [1:0]          mem_size,
    output logic [DATA_W-1:0]   mem_din,
    output logic                mem_wen,
    input  logic [DATA_W-1:0]   mem_dout
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("dmem_port_arbiter: STARVE_MAX must be within 1..15");
    end

    // Legal iff size is byte, or halfword/word naturally aligned.
    function automatic logic access_legal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (addr_lo[0] == 1'b0);
            2'b10:   ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic              starve_s;
    logic              sel0_s;
    logic              sel1_s;
    logic              sel_any_s;
    logic              sel_wr_s;
    logic [1:0]        sel_size_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              legal_s;
    logic              load0_s;
    logic              load1_s;

    logic              m0_rvalid_r;
    logic              m0_err_r;
    logic [DATA_W-1:0] m0_rdata_r;
    logic              m1_rvalid_r;
    logic              m1_err_r;
    logic [DATA_W-1:0] m1_rdata_r;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] sc_r;

    assign starve_s = (sc_r == STARVE_LIM);

    // Count consecutive denied port-1 request cycles, saturating at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc_r <= 4'd0;
        end else if (m1.req && !sel1_s) begin
            if (sc_r != STARVE_LIM) begin
                sc_r <= sc_r + 4'd1;
            end else begin
                sc_r <= sc_r;
            end
        end else begin
            sc_r <= 4'd0;
        end
    end
`else
    assign starve_s = 1'b0;
`endif

    // Port selection; reset holds every grant low.
    always_comb begin
        sel0_s = 1'b0;
        sel1_s = 1'b0;
        if (!rst) begin
            sel0_s = 1'b0;
            sel1_s = 1'b0;
        end else if (starve_s && m1.req) begin
            sel1_s = 1'b1;
        end else if (m0.req) begin
            sel0_s = 1'b1;
        end else if (m1.req) begin
            sel1_s = 1'b1;
        end else begin
            sel0_s = 1'b0;
            sel1_s = 1'b0;
        end
    end

    // Payload mux for the selected port; idle drives zeros.
    always_comb begin
        sel_wr_s    = 1'b0;
        sel_size_s  = 2'b00;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (sel0_s) begin
            sel_wr_s    = m0.wr;
            sel_size_s  = m0.size;
            sel_addr_s  = m0.addr;
            sel_wdata_s = m0.wdata;
        end else if (sel1_s) begin
            sel_wr_s    = m1.wr;
            sel_size_s  = m1.size;
            sel_addr_s  = m1.addr;
            sel_wdata_s = m1.wdata;
        end else begin
            sel_wr_s    = 1'b0;
            sel_size_s  = 2'b00;
            sel_addr_s  = '0;
            sel_wdata_s = '0;
        end
    end

    assign sel_any_s = sel0_s | sel1_s;
    assign legal_s   = access_legal(sel_size_s, sel_addr_s[1:0]);
    assign load0_s   = sel0_s & legal_s & ~sel_wr_s;
    assign load1_s   = sel1_s & legal_s & ~sel_wr_s;

    assign mem_addr = sel_addr_s;
    assign mem_size = sel_size_s;
    assign mem_din  = sel_wdata_s;

    // Write strobe only for a legal granted store.
    always_comb begin
        mem_wen = 1'b1;
        if (sel_any_s && legal_s && sel_wr_s) begin
            mem_wen = 1'b0;
        end else begin
            mem_wen = 1'b1;
        end
    end

    // Response registers: load data capture and one-cycle rvalid/err pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_rvalid_r <= 1'b0;
            m0_err_r    <= 1'b0;
            m0_rdata_r  <= '0;
            m1_rvalid_r <= 1'b0;
            m1_err_r    <= 1'b0;
            m1_rdata_r  <= '0;
        end else begin
            m0_rvalid_r <= load0_s;
            m0_err_r    <= sel0_s & ~legal_s;
            m1_rvalid_r <= load1_s;
            m1_err_r    <= sel1_s & ~legal_s;
            if (load0_s) begin
                m0_rdata_r <= mem_dout;
            end else begin
                m0_rdata_r <= m0_rdata_r;
            end
            if (load1_s) begin
                m1_rdata_r <= mem_dout;
            end else begin
                m1_rdata_r <= m1_rdata_r;
            end
        end
    end

    assign m0.gnt    = sel0_s;
    assign m0.rvalid = m0_rvalid_r;
    assign m0.err    = m0_err_r;
    assign m0.rdata  = m0_rdata_r;
    assign m1.gnt    = sel1_s;
    assign m1.rvalid = m1_rvalid_r;
    assign m1.err    = m1_err_r;
    assign m1.rdata  = m1_rdata_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word-addressed memory model.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_din;
    logic        mem_wen;
    logic [31:0] mem_dout;
    logic [31:0] mem_model [0:255];

    int n_checks;
    int n_fail;

    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p0 ();
    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1 ();

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0       (p0),
        .m1       (p1),
        .mem_addr (mem_addr),
        .mem_size (mem_size),
        .mem_din  (mem_din),
        .mem_wen  (mem_wen),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem_model[mem_addr[9:2]];

    always @(posedge clk) begin
        if (!mem_wen) mem_model[mem_addr[9:2]] <= mem_din;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic req, input logic wr,
                         input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0.req = req; p0.wr = wr; p0.size = size; p0.addr = addr; p0.wdata = wdata;
        end else begin
            p1.req = req; p1.wr = wr; p1.size = size; p1.addr = addr; p1.wdata = wdata;
        end
    endtask

    initial begin
        logic exp1;
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        rst      = 1'b0;
        drive(0, 1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

        // Reset: requests present but nothing granted, outputs at reset values.
        repeat (2) tick();
        #1;
        check_val("rst_gnt0",   {31'd0, p0.gnt}, 32'd0);
        check_val("rst_gnt1",   {31'd0, p1.gnt}, 32'd0);
        check_val("rst_wen",    {31'd0, mem_wen}, 32'd1);
        check_val("rst_addr",   mem_addr, 32'd0);
        check_val("rst_rvalid", {31'd0, p0.rvalid}, 32'd0);
        check_val("rst_rdata0", p0.rdata, 32'd0);
        check_val("rst_rdata1", p1.rdata, 32'd0);

        // Port 0 word store, granted in the first cycle with reset released.
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF);
        #1;
        check_val("st_gnt0", {31'd0, p0.gnt}, 32'd1);
        check_val("st_wen",  {31'd0, mem_wen}, 32'd0);
        check_val("st_addr", mem_addr, 32'h0000_0100);
        check_val("st_din",  mem_din, 32'hDEAD_BEEF);

        tick();
        drive(0, 1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
        #1;
        check_val("ld_gnt0",    {31'd0, p0.gnt}, 32'd1);
        check_val("ld_wen",     {31'd0, mem_wen}, 32'd1);
        check_val("st_norvalid", {31'd0, p0.rvalid}, 32'd0);

        tick();
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        check_val("ld_rvalid0", {31'd0, p0.rvalid}, 32'd1);
        check_val("ld_rdata0",  p0.rdata, 32'hDEAD_BEEF);
        check_val("idle_addr",  mem_addr, 32'd0);
        check_val("idle_din",   mem_din, 32'd0);
        check_val("idle_gnt0",  {31'd0, p0.gnt}, 32'd0);

        tick();
        check_val("rvalid0_pulse", {31'd0, p0.rvalid}, 32'd0);
        check_val("rdata0_hold",   p0.rdata, 32'hDEAD_BEEF);

        // Port 1 alone: store then byte load at 0x7.
        drive(1, 1'b1, 1'b1, 2'b10, 32'h0000_0004, 32'h1122_3344);
        #1;
        check_val("p1st_gnt1", {31'd0, p1.gnt}, 32'd1);
        check_val("p1st_gnt0", {31'd0, p0.gnt}, 32'd0);
        check_val("p1st_wen",  {31'd0, mem_wen}, 32'd0);

        tick();
        drive(1, 1'b1, 1'b0, 2'b00, 32'h0000_0007, 32'h0);
        #1;
        check_val("p1ld_gnt1", {31'd0, p1.gnt}, 32'd1);
        check_val("p1ld_addr", mem_addr, 32'h0000_0007);
        check_val("p1ld_wen",  {31'd0, mem_wen}, 32'd1);

        tick();
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        check_val("p1ld_rvalid", {31'd0, p1.rvalid}, 32'd1);
        check_val("p1ld_rdata",  p1.rdata, 32'h1122_3344);
        check_val("p1ld_err",    {31'd0, p1.err}, 32'd0);

        // Illegal accesses: misaligned halfword, then size 11.
        tick();
        drive(1, 1'b1, 1'b0, 2'b01, 32'h0000_0103, 32'h0);
        #1;
        check_val("hmis_gnt1", {31'd0, p1.gnt}, 32'd1);
        check_val("hmis_wen",  {31'd0, mem_wen}, 32'd1);
        check_val("hmis_size", {30'd0, mem_size}, 32'd1);

        tick();
        drive(1, 1'b1, 1'b1, 2'b11, 32'h0000_0000, 32'hFFFF_FFFF);
        #1;
        check_val("hmis_err",    {31'd0, p1.err}, 32'd1);
        check_val("hmis_norv",   {31'd0, p1.rvalid}, 32'd0);
        check_val("sz11_gnt1",   {31'd0, p1.gnt}, 32'd1);
        check_val("sz11_wen",    {31'd0, mem_wen}, 32'd1);

        tick();
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(0, 1'b1, 1'b1, 2'b10, 32'h0000_0102, 32'h0000_AAAA);
        #1;
        check_val("sz11_err",    {31'd0, p1.err}, 32'd1);
        check_val("sz11_norv",   {31'd0, p1.rvalid}, 32'd0);
        check_val("rdata1_hold", p1.rdata, 32'h1122_3344);
        check_val("wmis_gnt0",   {31'd0, p0.gnt}, 32'd1);
        check_val("wmis_wen",    {31'd0, mem_wen}, 32'd1);

        // Aligned halfword store at 0x102 is legal.
        tick();
        drive(0, 1'b1, 1'b1, 2'b01, 32'h0000_0102, 32'h0000_5555);
        #1;
        check_val("wmis_err",  {31'd0, p0.err}, 32'd1);
        check_val("wmis_norv", {31'd0, p0.rvalid}, 32'd0);
        check_val("hst_wen",   {31'd0, mem_wen}, 32'd0);
        check_val("err1_pulse", {31'd0, p1.err}, 32'd0);

        tick();
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        check_val("hst_noerr", {31'd0, p0.err}, 32'd0);

        // Continuous contention from both ports.
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(0, 1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
            drive(1, 1'b1, 1'b0, 2'b10, 32'h0000_0004, 32'h0);
            #1;
`ifdef DMEM_ARB_STARVE_GUARD_EN
            exp1 = ((k % 5) == 4);
`else
            exp1 = 1'b0;
`endif
            check_val($sformatf("cont_gnt1_%0d", k), {31'd0, p1.gnt}, {31'd0, exp1});
            check_val($sformatf("cont_gnt0_%0d", k), {31'd0, p0.gnt}, {31'd0, ~exp1});
            tick();
        end
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
`ifdef DMEM_ARB_STARVE_GUARD_EN
        check_val("cont_rv1", {31'd0, p1.rvalid}, 32'd1);
`else
        check_val("cont_rv1", {31'd0, p1.rvalid}, 32'd0);
`endif
        tick();

        // Reset asserted while a load response is in flight.
        drive(0, 1'b1, 1'b0, 2'b10, 32'h0000_0004, 32'h0);
        #1;
        check_val("mid_gnt0", {31'd0, p0.gnt}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_val("mid_gnt0_rst", {31'd0, p0.gnt}, 32'd0);
        check_val("mid_wen_rst",  {31'd0, mem_wen}, 32'd1);
        check_val("mid_rdata0",   p0.rdata, 32'd0);
        check_val("mid_rdata1",   p1.rdata, 32'd0);
        tick();
        check_val("mid_norvalid", {31'd0, p0.rvalid}, 32'd0);
        check_val("mid_addr",     mem_addr, 32'd0);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        check_val("post_norvalid", {31'd0, p0.rvalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port (address, size, write data, active-low write enable, read data) between two requesters: port 0, the pipeline MEM stage, and port 1, a program/data loader or debug master. Port 0 has fixed priority; a starvation guard forces a port-1 grant after a bounded wait. Size and alignment are checked before the memory is touched. Read data comes back registered, one cycle after the grant.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `STARVE_MAX`, 4, number of consecutive denied port-1 request cycles before port 1 is forced (range 1..15).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mN_req`  in  1  port N (N=0,1) request; held until `mN_gnt`.
- `mN_wr`  in  1  1 = store, 0 = load.
- `mN_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `mN_addr`  in  ADDR_W  byte address.
- `mN_wdata`  in  DATA_W  store data.
- `mN_gnt`  out  1  combinational grant; the access completes in this cycle.
- `mN_rvalid`  out  1  registered one-cycle pulse; load data is valid.
- `mN_rdata`  out  DATA_W  registered load data; holds until the next `mN_rvalid`.
- `mN_err`  out  1  registered one-cycle pulse; the granted access was illegal and memory was not accessed.
- `mem_addr`  out  ADDR_W  to the memory `Addr`.
- `mem_size`  out  2  to the memory `Size`.
- `mem_din`  out  DATA_W  to the memory `DataIn`.
- `mem_wen`  out  1  active-low write enable; 0 writes.
- `mem_dout`  in  DATA_W  combinational read data from the memory.

## Operation
- Selection each cycle, evaluated in this order:
  1. If the starve flag is set and `m1_req` is high, port 1 is selected.
  2. Otherwise, if `m0_req` is high, port 0 is selected.
  3. Otherwise, if `m1_req` is high, port 1 is selected.
  4. Otherwise no port is selected.
- Exactly one `gnt` is high at most.
- Datapath muxing: `mem_addr`, `mem_size` and `mem_din` follow the selected port. With no port selected they drive 0 and `mem_wen` = 1.
- Legality check on the selected access:
  - `size` = 11 is illegal.
  - Halfword with `addr[0]` = 1 is illegal.
  - Word with `addr[1:0]` ≠ 00 is illegal.
- Illegal access: the grant is still given, `mem_wen` is forced to 1, and `mN_err` pulses on the next cycle. `mN_rvalid` does not pulse.
- Legal store: `mem_wen` = 0 in the grant cycle. No `rvalid`.
- Legal load: `mem_dout` is captured at the clock edge into `mN_rdata`, and `mN_rvalid` pulses on the next cycle.
- Starvation counter `sc` (4 bits):
  - Increments while `m1_req` = 1 and `m1_gnt` = 0, saturating at `STARVE_MAX`.
  - Clears when `m1_gnt` = 1 or `m1_req` = 0.
  - The starve flag is `sc` == `STARVE_MAX`.
- Requesters must hold `req` and all payload stable until they see `gnt`. Dropping `req` before `gnt` withdraws the request; the arbiter takes no action.

## Timing
- Grant latency: 0 cycles when selected. Response latency: `rvalid`/`err` are asserted exactly 1 cycle after `gnt`.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed. The pipeline port is never blocked for more than 1 cycle in any `STARVE_MAX`+1 window.
- Simultaneous requests: port 0 wins unless the starve flag is set. After a forced port-1 grant, `sc` = 0, so port 0 wins again the next cycle.
- `rst` low, asserted at any time:
  - `sc` = 0 and all `rvalid`/`err` = 0, immediately.
  - `rdata` = 0.
  - All `gnt` = 0, `mem_wen` = 1, `mem_addr`/`mem_size`/`mem_din` = 0, held while `rst` is low.
  - An in-flight response that has not yet been delivered is discarded.
- Release: the first grant is possible in the first cycle with `rst` high.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined: the starvation counter and forced port-1 grant are built as described.
- Not defined: no counter and no starve flag. Pure fixed priority; port 1 is granted only in cycles where `m0_req` = 0.

## Test plan
- Reset and idle: `rst` low mid-load → `m0_rvalid` never pulses; all outputs hold the reset values; `mem_wen` = 1.
- Port 0 word store 0xDEADBEEF to 0x100, then load from 0x100 → `m0_gnt` in both cycles; `mem_wen` = 0 only in the store cycle; `m0_rvalid` one cycle after the load grant with `m0_rdata` = 0xDEADBEEF.
- Both ports request continuously, `STARVE_MAX` = 4, guard enabled → port 0 granted 4 cycles, port 1 granted on the 5th, pattern repeats. With the macro undefined, port 1 is never granted.
- Port 1 halfword load at 0x103 → `m1_gnt` = 1, `mem_wen` = 1, `m1_err` pulse next cycle, no `m1_rvalid`. Same result for `size` = 11 at 0x0.
- `m0_req` low, `m1_req` high → `m1_gnt` in the same cycle; `sc` stays 0; a byte load at 0x7 returns `mem_dout` one cycle later.
